// File: rtl/fpu_op_sequencer_if.sv
// Request, unit and response signals shared by the FPU op sequencer and its neighbours.
// The sequencer uses the slave modport. The issuing logic and the FP units together use master.
interface fpu_op_sequencer_if;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [1:0]   req_type;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic [3:0]   unit_start;
    logic         unit_dp;
    logic [63:0]  unit_a;
    logic [63:0]  unit_b;
    logic [3:0]   unit_done;
    logic [255:0] unit_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_result;
    logic         rsp_error;
    logic         busy;

    modport slave (
        input  req_valid, req_op, req_type, req_a, req_b,
        input  unit_done, unit_result, rsp_ready,
        output req_ready, unit_start, unit_dp, unit_a, unit_b,
        output rsp_valid, rsp_result, rsp_error, busy
    );

    modport master (
        output req_valid, req_op, req_type, req_a, req_b,
        output unit_done, unit_result, rsp_ready,
        input  req_ready, unit_start, unit_dp, unit_a, unit_b,
        input  rsp_valid, rsp_result, rsp_error, busy
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// FPU front-end sequencer. It accepts one request at a time and starts the matching unit.
// It then waits for that unit's done, with a watchdog, and returns the result over valid/ready.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a request; operands latched on acceptance
// S_ISSUE | one-cycle start pulse to unit[op]; watchdog cleared
// S_WAIT  | waiting for unit_done[op]; watchdog counting
// S_RESP  | response held on rsp_* until rsp_ready
module fpu_op_sequencer #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    fpu_op_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state, state_nxt;
    logic [1:0]     op_q;
    logic           dp_q;
    logic [63:0]    a_q, b_q;
    logic [WD_W-1:0] wd_q;
    logic [63:0]    res_q;
    logic           err_q;

    logic           done_sel;
    logic           wd_tc;
    logic [63:0]    sel_result;
    logic           req_dp;
    logic           req_bad;

    assign done_sel   = bus.unit_done[op_q];
    // The final WAIT cycle is the one in which the count would reach TIMEOUT_CYC.
    assign wd_tc      = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign sel_result = bus.unit_result[{op_q, 6'd0} +: 64];
    assign req_dp     = (bus.req_type == 2'd1);
    assign req_bad    = bus.req_type[1];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode. Done takes priority over the watchdog in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid) state_nxt = req_bad ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_sel || wd_tc) state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake and start outputs are decoded from state, so reset drops them at once.
    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.busy       = (state != S_IDLE);
        bus.rsp_valid  = (state == S_RESP);
        bus.unit_start = 4'b0000;
        if (state == S_ISSUE) bus.unit_start[op_q] = 1'b1;
    end

    // Request latch, watchdog and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= 2'd0;
            dp_q  <= 1'b0;
            a_q   <= 64'd0;
            b_q   <= 64'd0;
            wd_q  <= '0;
            res_q <= 64'd0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        dp_q <= req_dp;
                        a_q  <= req_dp ? bus.req_a : {32'd0, bus.req_a[31:0]};
                        b_q  <= req_dp ? bus.req_b : {32'd0, bus.req_b[31:0]};
                        if (req_bad) begin
                            res_q <= 64'd0;
                            err_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: wd_q <= '0;
                S_WAIT: begin
                    if (done_sel) begin
                        res_q <= dp_q ? sel_result : {32'd0, sel_result[31:0]};
                        err_q <= 1'b0;
                    end else if (wd_tc) begin
                        res_q <= 64'd0;
                        err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.unit_dp    = dp_q;
    assign bus.unit_a     = a_q;
    assign bus.unit_b     = b_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_error  = err_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a response scoreboard.
// The stimulus pushes the expected response for each request it issues.
// Monitors pop and compare on each rsp handshake.
// A second instance built with TIMEOUT_CYC=15 covers the watchdog cases.
module tb_fpu_op_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_op_sequencer_if bus ();
    fpu_op_sequencer_if bus_t ();

    fpu_op_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    fpu_op_sequencer #(.TIMEOUT_CYC(15)) dut_t (.clk(clk), .reset(reset), .bus(bus_t));

    typedef struct packed { logic [63:0] res; logic err; } exp_t;
    exp_t exp_q[$];
    exp_t exp_tq[$];

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;
    int rsp_t_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: one comparison set per response handshake
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got %h/%0b expected none", bus.rsp_result, bus.rsp_error);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_result", bus.rsp_result, e.res);
                chk("rsp_error", {63'd0, bus.rsp_error}, {63'd0, e.err});
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && bus_t.rsp_valid && bus_t.rsp_ready) begin
            rsp_t_seen++;
            if (exp_tq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp_t: got %h/%0b expected none", bus_t.rsp_result, bus_t.rsp_error);
            end else begin
                e = exp_tq.pop_front();
                chk("rsp_t_result", bus_t.rsp_result, e.res);
                chk("rsp_t_error", {63'd0, bus_t.rsp_error}, {63'd0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    // Call at one time unit after a posedge. Returns one time unit after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [1:0] typ, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!bus.req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_wait: got 0 expected 1");
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_type = typ;
        bus.req_a = a; bus.req_b = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic done_pulse(input int k, input logic [63:0] r);
        bus.unit_result[k*64 +: 64] = r;
        bus.unit_done[k] = 1'b1;
        @(posedge clk); #1;
        bus.unit_done[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.busy && n < 2000);
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy=1 expected 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
        chk({tag, "_unit_start"}, {60'd0, bus.unit_start}, 64'd0);
        chk({tag, "_unit_dp"}, {63'd0, bus.unit_dp}, 64'd0);
        chk({tag, "_unit_a"}, bus.unit_a, 64'd0);
        chk({tag, "_unit_b"}, bus.unit_b, 64'd0);
        chk({tag, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 64'd0);
        chk({tag, "_rsp_error"}, {63'd0, bus.rsp_error}, 64'd0);
        chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int n;
        bus.req_valid = 0; bus.req_op = 0; bus.req_type = 0; bus.req_a = 0; bus.req_b = 0;
        bus.unit_done = 0; bus.unit_result = '0; bus.rsp_ready = 1;
        bus_t.req_valid = 0; bus_t.req_op = 0; bus_t.req_type = 0; bus_t.req_a = 0; bus_t.req_b = 0;
        bus_t.unit_done = 0; bus_t.unit_result = '0; bus_t.rsp_ready = 1;

        @(negedge clk); @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: SP add. Garbage in upper halves must be zeroed.
        exp_q.push_back('{64'h0000_0000_4040_0000, 1'b0});
        send(2'b00, 2'd0, 64'hDEAD_BEEF_3F80_0000, 64'hCAFE_F00D_4000_0000);
        @(negedge clk);
        chk("t1_start", {60'd0, bus.unit_start}, 64'h1);
        chk("t1_dp", {63'd0, bus.unit_dp}, 64'd0);
        chk("t1_unit_a", bus.unit_a, 64'h0000_0000_3F80_0000);
        chk("t1_unit_b", bus.unit_b, 64'h0000_0000_4000_0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_start_off", {60'd0, bus.unit_start}, 64'd0);
        chk("t1_busy", {63'd0, bus.busy}, 64'd1);
        chk("t1_req_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        done_pulse(0, 64'hFFFF_FFFF_4040_0000);
        wait_idle();

        // 2: DP div, 20-cycle unit, rsp_ready held low for 5 cycles
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{64'h4000_0000_0000_0000, 1'b0});
        send(2'b11, 2'd1, 64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000);
        @(negedge clk);
        chk("t2_start", {60'd0, bus.unit_start}, 64'h8);
        chk("t2_dp", {63'd0, bus.unit_dp}, 64'd1);
        chk("t2_unit_a", bus.unit_a, 64'h4010_0000_0000_0000);
        repeat (20) begin @(posedge clk); #1; end
        done_pulse(3, 64'h4000_0000_0000_0000);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("t2_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("t2_hold_result", bus.rsp_result, 64'h4000_0000_0000_0000);
            chk("t2_hold_error", {63'd0, bus.rsp_error}, 64'd0);
            chk("t2_hold_dp", {63'd0, bus.unit_dp}, 64'd1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // 3: done during ISSUE and done from the wrong unit are both ignored
        exp_q.push_back('{64'h4008_0000_0000_0000, 1'b0});
        send(2'b10, 2'd1, 64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000);
        done_pulse(2, 64'h0000_0000_0000_0BAD);
        done_pulse(0, 64'h1111_1111_1111_1111);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t3_no_rsp_yet", {63'd0, bus.rsp_valid}, 64'd0);
        @(posedge clk); #1;
        done_pulse(2, 64'h4008_0000_0000_0000);
        wait_idle();

        // 4: timeout after 15 WAIT cycles on the TIMEOUT_CYC=15 instance
        exp_tq.push_back('{64'd0, 1'b1});
        bus_t.req_valid = 1; bus_t.req_op = 2'b01; bus_t.req_type = 2'd0;
        bus_t.req_a = 64'h3F80_0000; bus_t.req_b = 64'h3F80_0000;
        @(posedge clk); #1;
        bus_t.req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_t.rsp_valid && n < 100);
        chk("t4_wait_cycles", 64'(n - 2), 64'd15);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 4b: done in the 15th WAIT cycle beats the timeout
        exp_tq.push_back('{64'h0000_0000_4120_0000, 1'b0});
        bus_t.req_valid = 1;
        @(posedge clk); #1;
        bus_t.req_valid = 0;
        repeat (15) begin @(posedge clk); #1; end
        bus_t.unit_result[127:64] = 64'h1234_5678_4120_0000;
        bus_t.unit_done[1] = 1'b1;
        @(posedge clk); #1;
        bus_t.unit_done[1] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // 5: illegal type, then a legal SP mul
        exp_q.push_back('{64'd0, 1'b1});
        send(2'b00, 2'd2, 64'h1, 64'h2);
        @(negedge clk);
        chk("t5_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("t5_no_start", {60'd0, bus.unit_start}, 64'd0);
        chk("t5_req_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        wait_idle();
        exp_q.push_back('{64'h0000_0000_40C0_0000, 1'b0});
        send(2'b10, 2'd0, 64'h4040_0000, 64'h4000_0000);
        @(posedge clk); #1;
        done_pulse(2, 64'h0000_0000_40C0_0000);
        wait_idle();

        // 6: reset during WAIT, then recovery with a DP sub
        send(2'b00, 2'd1, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk_reset_values("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk); #1;
        exp_q.push_back('{64'h4000_0000_0000_0000, 1'b0});
        send(2'b01, 2'd1, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000);
        @(posedge clk); #1;
        done_pulse(1, 64'h4000_0000_0000_0000);
        wait_idle();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("sb_t_empty", 64'(exp_tq.size()), 64'd0);
        chk("rsp_count", 64'(rsp_seen), 64'd6);
        chk("rsp_t_count", 64'(rsp_t_seen), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
